idu_pipe: RTL and testbench
===========================

# idu_pipe

Parametrised, pipelined RISC-V instruction decode stage sitting between the IFU and the EXU in the NPC core. It accepts one fetched instruction and its PC per valid/ready handshake and produces register indices, fully format-aware sign-extended immediates, format code and register-enable flags from a registered output stage. A two-entry skid buffer keeps `in_ready` registered, and a synchronous flush input supports branch redirects.

## Interface
- `XLEN`, default 32: datapath width, either 32 or 64. Sets the PC and immediate width. When 64, the RV64 `*W` opcodes are decoded.
- `clk` input 1: the single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous; discards all buffered entries.
- `in_valid` input 1, `in_ready` output 1: upstream handshake.
- `in_inst` input 32: instruction word.
- `in_pc` input XLEN: instruction PC.
- `out_valid` output 1, `out_ready` input 1: downstream handshake.
- `out_pc` output XLEN: PC of the decoded instruction.
- `out_inst` output 32: raw instruction, passed through.
- `out_opcode` output 7, `out_funct3` output 3, `out_funct7` output 7: instruction fields.
- `out_rs1` output 5, `out_rs2` output 5, `out_rd` output 5: register indices.
- `out_imm` output XLEN: sign-extended immediate.
- `out_fmt` output 3: format code. R=0, I=1, S=2, B=3, U=4, J=5, unknown=7.
- `out_rs1_en` output 1, `out_rs2_en` output 1: source-register read enables.
- `out_rd_wen` output 1: destination write enable.
- `out_illegal` output 1: illegal-instruction flag; see Configuration.
- `out_count` output 32: count of completed output handshakes.

## Operation
- **Fields:** opcode = [6:0], rd = [11:7], funct3 = [14:12], rs1 = [19:15], rs2 = [24:20], funct7 = [31:25].
- **Opcode to format:**
  - R: 0110011; also 0111011 when XLEN=64.
  - I: 0010011, 0000011, 1100111, 1110011; also 0011011 when XLEN=64.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - Anything else: fmt=7, imm=0, all enables 0.
- **Immediates:** every value below is sign-extended from bit 31 to XLEN.
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
  - R: 0.
- **Enables:**
  - rs1_en: fmt in {R, I, S, B}.
  - rs2_en: fmt in {R, S, B}.
  - rd_wen: fmt in {R, I, U, J} and rd != 0. Exception: for opcode 1110011, rd_wen is set only when funct3 != 0.
- **Decode placement:** decode is combinational on the input. Results are captured into the main output register or into the skid register.
- **Buffer states:** EMPTY (no entry valid), ONE (main valid), TWO (main and skid valid).
  - `in_ready` = !skid_valid, driven from a flop.
  - Accepted input goes to main if main is empty or is handshaking this cycle; otherwise it goes to skid.
  - On an output handshake in state TWO, skid moves to main. If an input is also accepted that cycle, it goes to skid.
  - Order is strictly FIFO; payloads are never dropped or duplicated.
- **Flush:** highest priority. Next state is EMPTY. An input accepted in the flush cycle is discarded. `out_count` is unaffected.
- **Counter:** `out_count` increments on each `out_valid && out_ready` and wraps 0xFFFFFFFF → 0.

## Timing
- **Reset:** all outputs are 0, except `in_ready`=1. State is EMPTY.
- **Latency:** accept at edge N gives `out_valid`=1 after edge N.
- **Throughput:** 1 instruction per cycle while `out_ready`=1.
- **Backpressure:** with `out_ready`=0, two instructions are accepted. `in_ready` falls after the second accept edge and rises one cycle after the next output handshake.
- **Payload stability:** payload holds stable while `out_valid` && !`out_ready`.
- **Reset mid-operation:** all entries are lost immediately; outputs return to reset values asynchronously.
- **Flush and output handshake in the same cycle:** the handshake counts, then the buffer empties.

## Configuration
- `IDU_ILLEGAL_CHK_EN` defined: `out_illegal`=1 in any of these cases:
  - inst[1:0] != 2'b11;
  - fmt=7;
  - an R-type whose funct7 is not in {0000000, 0100000, 0000001}.
  Illegal entries still flow through the handshake normally.
- `IDU_ILLEGAL_CHK_EN` undefined: `out_illegal` is tied to 0 and no check logic is built.

## Test plan
- **addi 0xFFF10093** → rd=1, rs1=2, imm=0xFFFFFFFF, fmt=1, rs1_en=1, rs2_en=0, rd_wen=1, pc echoed.
- **Immediate formats, back-to-back at XLEN=32 with out_ready=1:**
  - sw 0x00512423 → imm=8, rs1=2, rs2=5, fmt=2, rd_wen=0.
  - beq 0xFE000EE3 → imm=0xFFFFFFFC, fmt=3.
  - jal 0x001000EF → imm=0x800, rd=1.
  - lui 0x123451B7 → imm=0x12345000, rd=3.
  - Throughput must be one per cycle.
- **Backpressure:** hold out_ready=0 and offer 3 instructions. Only 2 are accepted and in_ready=0. Release out_ready; all 3 emerge in order and out_count=3.
- **Flush:** flush while in state TWO with in_valid=1 → out_valid=0 next cycle, in_ready=1, no stale output afterwards.
- **Illegal input:** 0x00000000 → out_illegal=1 with the macro, 0 without; in both builds fmt=7, imm=0, rd_wen=0.
- **Reset and XLEN=64:** assert rst_n=0 while in state TWO → out_valid=0, out_count=0, in_ready=1. With XLEN=64, addiw 0xFFF1009B → fmt=1, imm=0xFFFFFFFFFFFFFFFF.

Source files
------------

// File: rtl/idu_pipe.sv
// Pipelined RV32/RV64 instruction decode stage with a two-entry skid buffer and synchronous flush.
// Optional illegal-instruction checking is built when IDU_ILLEGAL_CHK_EN is defined.
module idu_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_rs1_en,
  output logic            out_rs2_en,
  output logic            out_rd_wen,
  output logic            out_illegal,
  output logic [31:0]     out_count
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5,
    FMT_X = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            rs1_en;
    logic            rs2_en;
    logic            rd_wen;
    logic            illegal;
  } entry_t;

  entry_t             dec;
  fmt_e               fmt_dec;
  logic signed [31:0] imm32;

  entry_t      main_reg, main_next;
  entry_t      skid_reg, skid_next;
  logic        main_valid_reg, main_valid_next;
  logic        skid_valid_reg, skid_valid_next;
  logic        in_ready_reg;
  logic [31:0] count_reg;
  logic        in_fire, out_fire;

  assign in_fire  = in_valid && in_ready_reg;
  assign out_fire = main_valid_reg && out_ready;

  always_comb begin
    fmt_dec = FMT_X;
    case (in_inst[6:0])
      7'b0110011: fmt_dec = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: fmt_dec = FMT_I;
      7'b0100011: fmt_dec = FMT_S;
      7'b1100011: fmt_dec = FMT_B;
      7'b0110111, 7'b0010111: fmt_dec = FMT_U;
      7'b1101111: fmt_dec = FMT_J;
      7'b0111011: if (XLEN == 64) fmt_dec = FMT_R;
      7'b0011011: if (XLEN == 64) fmt_dec = FMT_I;
      default: fmt_dec = FMT_X;
    endcase
  end

  // Immediates are built at 32 bits then sign-extended to XLEN by a signed cast.
  always_comb begin
    imm32 = '0;
    case (fmt_dec)
      FMT_I: imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      FMT_S: imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      FMT_B: imm32 = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      FMT_U: imm32 = {in_inst[31:12], 12'b0};
      FMT_J: imm32 = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  always_comb begin
    dec        = '0;
    dec.pc     = in_pc;
    dec.inst   = in_inst;
    dec.imm    = XLEN'(imm32);
    dec.fmt    = fmt_dec;
    dec.rs1_en = (fmt_dec == FMT_R) || (fmt_dec == FMT_I) || (fmt_dec == FMT_S) || (fmt_dec == FMT_B);
    dec.rs2_en = (fmt_dec == FMT_R) || (fmt_dec == FMT_S) || (fmt_dec == FMT_B);
    // SYSTEM with funct3=0 (ecall/ebreak/xret) never writes a register.
    dec.rd_wen = ((fmt_dec == FMT_R) || (fmt_dec == FMT_I) || (fmt_dec == FMT_U) || (fmt_dec == FMT_J))
                 && (in_inst[11:7] != 5'd0)
                 && !((in_inst[6:0] == 7'b1110011) && (in_inst[14:12] == 3'd0));
`ifdef IDU_ILLEGAL_CHK_EN
    dec.illegal = (in_inst[1:0] != 2'b11) || (fmt_dec == FMT_X)
                  || ((fmt_dec == FMT_R) && (in_inst[31:25] != 7'b0000000)
                      && (in_inst[31:25] != 7'b0100000) && (in_inst[31:25] != 7'b0000001));
`else
    dec.illegal = 1'b0;
`endif
  end

  // Output handshake frees main first, so an incoming entry lands in main whenever main ends up empty.
  always_comb begin
    main_next       = main_reg;
    skid_next       = skid_reg;
    main_valid_next = main_valid_reg;
    skid_valid_next = skid_valid_reg;
    if (flush) begin
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else begin
      if (out_fire) begin
        main_next       = skid_reg;
        main_valid_next = skid_valid_reg;
        skid_valid_next = 1'b0;
      end
      if (in_fire) begin
        if (!main_valid_next) begin
          main_next       = dec;
          main_valid_next = 1'b1;
        end else begin
          skid_next       = dec;
          skid_valid_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_reg       <= '0;
      skid_reg       <= '0;
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      in_ready_reg   <= 1'b1;
      count_reg      <= '0;
    end else begin
      main_reg       <= main_next;
      skid_reg       <= skid_next;
      main_valid_reg <= main_valid_next;
      skid_valid_reg <= skid_valid_next;
      in_ready_reg   <= !skid_valid_next;
      if (out_fire) count_reg <= count_reg + 32'd1;
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = main_valid_reg;
  assign out_pc      = main_reg.pc;
  assign out_inst    = main_reg.inst;
  assign out_opcode  = main_reg.inst[6:0];
  assign out_rd      = main_reg.inst[11:7];
  assign out_funct3  = main_reg.inst[14:12];
  assign out_rs1     = main_reg.inst[19:15];
  assign out_rs2     = main_reg.inst[24:20];
  assign out_funct7  = main_reg.inst[31:25];
  assign out_imm     = main_reg.imm;
  assign out_fmt     = main_reg.fmt;
  assign out_rs1_en  = main_reg.rs1_en;
  assign out_rs2_en  = main_reg.rs2_en;
  assign out_rd_wen  = main_reg.rd_wen;
  assign out_illegal = main_reg.illegal;
  assign out_count   = count_reg;

endmodule

// File: tb/tb_idu_pipe.sv
// Self-checking bench for idu_pipe: directed vector table, multi-cycle sequences, randomized scoreboard run.
module tb_idu_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc, out_inst, out_imm, out_count;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_funct3, out_fmt;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_rs1_en, out_rs2_en, out_rd_wen, out_illegal;

  logic        in_valid64 = 1'b0;
  logic        in_ready64;
  logic [31:0] in_inst64 = '0;
  logic [63:0] in_pc64 = '0;
  logic        out_valid64;
  logic        out_ready64 = 1'b1;
  logic [63:0] out_pc64, out_imm64;
  logic [31:0] out_inst64, out_count64;
  logic [6:0]  out_opcode64, out_funct7_64;
  logic [2:0]  out_funct3_64, out_fmt64;
  logic [4:0]  out_rs1_64, out_rs2_64, out_rd64;
  logic        out_rs1_en64, out_rs2_en64, out_rd_wen64, out_illegal64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  idu_pipe #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_rs1_en(out_rs1_en), .out_rs2_en(out_rs2_en), .out_rd_wen(out_rd_wen),
    .out_illegal(out_illegal), .out_count(out_count)
  );

  idu_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_inst(in_inst64), .in_pc(in_pc64),
    .out_valid(out_valid64), .out_ready(out_ready64), .out_pc(out_pc64), .out_inst(out_inst64),
    .out_opcode(out_opcode64), .out_funct3(out_funct3_64), .out_funct7(out_funct7_64),
    .out_rs1(out_rs1_64), .out_rs2(out_rs2_64), .out_rd(out_rd64), .out_imm(out_imm64), .out_fmt(out_fmt64),
    .out_rs1_en(out_rs1_en64), .out_rs2_en(out_rs2_en64), .out_rd_wen(out_rd_wen64),
    .out_illegal(out_illegal64), .out_count(out_count64)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  en;   // {rs1_en, rs2_en, rd_wen}
    logic        ill;  // expected only when the illegal check is built
  } vec_t;

  typedef struct {
    logic [31:0] pc, inst, imm;
    logic [2:0]  fmt;
    logic [2:0]  en;
    logic        ill;
  } exp_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ill_exp(input logic v);
`ifdef IDU_ILLEGAL_CHK_EN
    return v;
`else
    return 1'b0;
`endif
  endfunction

  // Reference decode computed arithmetically from the instruction-set immediate rules.
  function automatic exp_t ref_dec(input logic [31:0] inst, input logic [31:0] pc);
    exp_t r;
    int v;
    logic [6:0] op;
    logic bad;
    op = inst[6:0];
    r.pc = pc;
    r.inst = inst;
    case (op)
      7'h33: r.fmt = 3'd0;
      7'h13, 7'h03, 7'h67, 7'h73: r.fmt = 3'd1;
      7'h23: r.fmt = 3'd2;
      7'h63: r.fmt = 3'd3;
      7'h37, 7'h17: r.fmt = 3'd4;
      7'h6F: r.fmt = 3'd5;
      default: r.fmt = 3'd7;
    endcase
    v = 0;
    case (r.fmt)
      3'd1: v = int'(inst[30:20]) - (inst[31] ? 2048 : 0);
      3'd2: v = int'({inst[30:25], inst[11:7]}) - (inst[31] ? 2048 : 0);
      3'd3: v = int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2 - (inst[31] ? 4096 : 0);
      3'd4: v = int'(inst[31:12]) * 4096;
      3'd5: v = int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2 - (inst[31] ? 1048576 : 0);
      default: v = 0;
    endcase
    r.imm = 32'(v);
    r.en[2] = (r.fmt <= 3'd3);
    r.en[1] = (r.fmt == 3'd0) || (r.fmt == 3'd2) || (r.fmt == 3'd3);
    r.en[0] = ((r.fmt == 3'd0) || (r.fmt == 3'd1) || (r.fmt == 3'd4) || (r.fmt == 3'd5))
              && (inst[11:7] != 5'd0) && !(op == 7'h73 && inst[14:12] == 3'd0);
    bad = (inst[1:0] != 2'b11) || (r.fmt == 3'd7)
          || (r.fmt == 3'd0 && inst[31:25] != 7'h00 && inst[31:25] != 7'h20 && inst[31:25] != 7'h01);
    r.ill = ill_exp(bad);
    return r;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  vec_t tbl[11];
  exp_t q[$];
  exp_t e;
  logic [6:0] ops[10];

  initial begin
    tbl[0]  = '{32'hFFF10093, 32'hFFFFFFFF, 3'd1, 5'd1,  5'd2, 5'd31, 3'b101, 1'b0}; // addi
    tbl[1]  = '{32'h00512423, 32'h00000008, 3'd2, 5'd8,  5'd2, 5'd5,  3'b110, 1'b0}; // sw
    tbl[2]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 5'd29, 5'd0, 5'd0,  3'b110, 1'b0}; // beq
    tbl[3]  = '{32'h001000EF, 32'h00000800, 3'd5, 5'd1,  5'd0, 5'd1,  3'b001, 1'b0}; // jal
    tbl[4]  = '{32'h123451B7, 32'h12345000, 3'd4, 5'd3,  5'd8, 5'd3,  3'b001, 1'b0}; // lui
    tbl[5]  = '{32'h002081B3, 32'h00000000, 3'd0, 5'd3,  5'd1, 5'd2,  3'b111, 1'b0}; // add
    tbl[6]  = '{32'h082081B3, 32'h00000000, 3'd0, 5'd3,  5'd1, 5'd2,  3'b111, 1'b1}; // bad funct7
    tbl[7]  = '{32'h300022F3, 32'h00000300, 3'd1, 5'd5,  5'd0, 5'd0,  3'b101, 1'b0}; // csrrs
    tbl[8]  = '{32'h000002F3, 32'h00000000, 3'd1, 5'd5,  5'd0, 5'd0,  3'b100, 1'b0}; // system f3=0
    tbl[9]  = '{32'h00000000, 32'h00000000, 3'd7, 5'd0,  5'd0, 5'd0,  3'b000, 1'b1}; // all zero
    tbl[10] = '{32'h002081BB, 32'h00000000, 3'd7, 5'd3,  5'd1, 5'd2,  3'b000, 1'b1}; // addw on RV32
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    // Reset state
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_count", 64'(out_count), 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'd0);
    chk("rst_out_imm", 64'(out_imm), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Back-to-back table vectors with out_ready=1: one result per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1;
      in_inst = tbl[i].inst;
      in_pc = 32'h1000 + 32'(i * 4);
      step();
      chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'd1);
      chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("tbl%0d_pc", i), 64'(out_pc), 64'(32'h1000 + 32'(i * 4)));
      chk($sformatf("tbl%0d_imm", i), 64'(out_imm), 64'(tbl[i].imm));
      chk($sformatf("tbl%0d_fmt", i), 64'(out_fmt), 64'(tbl[i].fmt));
      chk($sformatf("tbl%0d_regs", i), 64'({out_rd, out_rs1, out_rs2}), 64'({tbl[i].rd, tbl[i].rs1, tbl[i].rs2}));
      chk($sformatf("tbl%0d_en", i), 64'({out_rs1_en, out_rs2_en, out_rd_wen}), 64'(tbl[i].en));
      chk($sformatf("tbl%0d_illegal", i), 64'(out_illegal), 64'(ill_exp(tbl[i].ill)));
    end
    in_valid = 1'b0;
    step();
    chk("tbl_drain_valid", 64'(out_valid), 64'd0);
    chk("tbl_count", 64'(out_count), 64'd11);

    // XLEN=64 instance: addiw, addw, beq
    in_valid64 = 1'b1;
    in_inst64 = 32'hFFF1009B;
    in_pc64 = 64'h8000_0000_0000_0010;
    step();
    chk("x64_addiw_fmt", 64'(out_fmt64), 64'd1);
    chk("x64_addiw_imm", out_imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("x64_addiw_pc", out_pc64, 64'h8000_0000_0000_0010);
    in_inst64 = 32'h002081BB;
    step();
    chk("x64_addw_fmt", 64'(out_fmt64), 64'd0);
    chk("x64_addw_en", 64'({out_rs1_en64, out_rs2_en64, out_rd_wen64}), 64'b111);
    in_inst64 = 32'hFE000EE3;
    step();
    chk("x64_beq_imm", out_imm64, 64'hFFFF_FFFF_FFFF_FFFC);
    in_valid64 = 1'b0;

    // Backpressure: three offered, two accepted, all three drain in order
    do_reset();
    in_valid = 1'b1; in_inst = tbl[0].inst; in_pc = 32'hA0;
    step();
    chk("bp_ready_after1", 64'(in_ready), 64'd1);
    in_inst = tbl[1].inst; in_pc = 32'hA4;
    step();
    chk("bp_ready_after2", 64'(in_ready), 64'd0);
    in_inst = tbl[4].inst; in_pc = 32'hA8;
    step();
    chk("bp_hold_ready", 64'(in_ready), 64'd0);
    chk("bp_hold_inst", 64'(out_inst), 64'(tbl[0].inst));
    out_ready = 1'b1;
    step();
    chk("bp_out2_inst", 64'(out_inst), 64'(tbl[1].inst));
    chk("bp_ready_rise", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp_out3_inst", 64'(out_inst), 64'(tbl[4].inst));
    chk("bp_out3_pc", 64'(out_pc), 64'h0A8);
    step();
    chk("bp_empty", 64'(out_valid), 64'd0);
    chk("bp_count", 64'(out_count), 64'd3);

    // Flush in state TWO with a pending input
    do_reset();
    in_valid = 1'b1; in_inst = tbl[0].inst;
    step();
    in_inst = tbl[1].inst;
    step();
    in_inst = tbl[2].inst; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("fl_stale%0d", i), 64'(out_valid), 64'd0);
    end
    chk("fl_count", 64'(out_count), 64'd0);

    // Asynchronous reset while in state TWO with a nonzero count
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_inst = tbl[3].inst;
    step();
    in_inst = tbl[4].inst;
    step();
    out_ready = 1'b0; in_inst = tbl[5].inst;
    step();
    in_valid = 1'b0;
    chk("ar_two_ready", 64'(in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'd0);
    chk("ar_count", 64'(out_count), 64'd0);
    chk("ar_in_ready", 64'(in_ready), 64'd1);
    chk("ar_out_inst", 64'(out_inst), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Randomized run against a depth-2 FIFO scoreboard
    begin
      logic in_fire, out_fire;
      logic [31:0] cnt;
      logic [31:0] inst;
      cnt = 0;
      q.delete();
      for (int c = 0; c < 3000; c++) begin
        inst = $urandom;
        if ($urandom_range(0, 9) < 8) inst[6:0] = ops[$urandom_range(0, 9)];
        if ($urandom_range(0, 7) == 0) inst[11:7] = 5'd0;
        in_inst = inst;
        in_pc = $urandom;
        in_valid = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        flush = ($urandom_range(0, 39) == 0);
        #0;
        checks++;
        if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) || out_count !== cnt) begin
          errors++;
          $display("FAIL rnd_ctrl cyc=%0d valid=%0b ready=%0b count=%0d exp_occ=%0d exp_count=%0d",
                   c, out_valid, in_ready, out_count, q.size(), cnt);
        end
        in_fire = in_valid && (q.size() < 2);
        out_fire = out_ready && (q.size() > 0);
        if (out_fire) begin
          e = q.pop_front();
          cnt = cnt + 32'd1;
          checks++;
          if (out_pc !== e.pc || out_inst !== e.inst || out_imm !== e.imm || out_fmt !== e.fmt
              || {out_rs1_en, out_rs2_en, out_rd_wen} !== e.en || out_illegal !== e.ill
              || out_opcode !== e.inst[6:0] || out_rd !== e.inst[11:7] || out_funct3 !== e.inst[14:12]
              || out_rs1 !== e.inst[19:15] || out_rs2 !== e.inst[24:20] || out_funct7 !== e.inst[31:25]) begin
            errors++;
            $display("FAIL rnd_payload cyc=%0d inst=%h/%h pc=%h/%h imm=%h/%h fmt=%0d/%0d en=%b/%b ill=%b/%b",
                     c, out_inst, e.inst, out_pc, e.pc, out_imm, e.imm, out_fmt, e.fmt,
                     {out_rs1_en, out_rs2_en, out_rd_wen}, e.en, out_illegal, e.ill);
          end
        end
        if (in_fire) q.push_back(ref_dec(inst, in_pc));
        if (flush) q.delete();
        step();
      end
      flush = 1'b0; in_valid = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
